// File: rtl/codificador_prioritario_if.sv
// Keypad-to-BCD bus for codificador_prioritario: key lines and enable in, registered digit and strobes out.
interface codificador_prioritario_if;
  logic [9:0] entrada;
  logic       enablen;
  logic [3:0] BCD;
  logic       valido;
  logic       nova_tecla;

  modport master (
    output entrada,
    output enablen,
    input  BCD,
    input  valido,
    input  nova_tecla
  );

  modport slave (
    input  entrada,
    input  enablen,
    output BCD,
    output valido,
    output nova_tecla
  );
endinterface

// File: rtl/codificador_prioritario.sv
// Registered 10-to-4 priority encoder (highest key index wins) with valid flag and new-key strobe.
// Optional input debouncing is compiled in with `define CODIFICADOR_DEBOUNCE_EN.
module codificador_prioritario #(
  parameter int DEBOUNCE_CICLOS = 4
) (
  input logic                      clk,
  input logic                      reset,
  codificador_prioritario_if.slave bus
);

  if ((DEBOUNCE_CICLOS < 1) || (DEBOUNCE_CICLOS > 255)) begin : g_param_check
    $error("codificador_prioritario: DEBOUNCE_CICLOS out of range 1..255");
  end

  function automatic logic [3:0] prio_code(input logic [9:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (v[i]) begin
        c = 4'(i);
      end
    end
    return c;
  endfunction

  logic [3:0] code_s;
  logic       any_s;
  logic       accept_s;
  logic       nova_s;
  logic [3:0] bcd_r;
  logic       valido_r;
  logic       nova_r;

  // Priority code and key-present flag for the current key lines.
  always_comb begin
    code_s = prio_code(bus.entrada);
    any_s  = |bus.entrada;
  end

`ifdef CODIFICADOR_DEBOUNCE_EN
  localparam logic [7:0] DEB_LIM = 8'(DEBOUNCE_CICLOS);

  logic [4:0] prev_r;
  logic [7:0] cnt_r;
  logic [4:0] sample_s;
  logic       stable_s;

  // Acceptance only after the sampled {any, code} has been seen unchanged for DEB_LIM edges.
  always_comb begin
    sample_s = {any_s, code_s};
    stable_s = (sample_s == prev_r);
    accept_s = stable_s && (cnt_r >= DEB_LIM);
  end

  // Stability counter: reload on change, saturating count while stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_r <= 5'd0;
      cnt_r  <= 8'd0;
    end else if (bus.enablen) begin
      prev_r <= 5'd0;
      cnt_r  <= 8'd0;
    end else if (stable_s) begin
      if (cnt_r != 8'hFF) begin
        cnt_r <= cnt_r + 8'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end else begin
      prev_r <= sample_s;
      cnt_r  <= 8'd1;
    end
  end
`else
  // Without debouncing every enabled edge is an acceptance.
  always_comb begin
    accept_s = 1'b1;
  end
`endif

  // New-key strobe: a present key that is either fresh after idle or a different digit.
  always_comb begin
    nova_s = accept_s && any_s && (!valido_r || (code_s != bcd_r));
  end

  // Output registers; disable forces idle immediately, holding otherwise until acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      bcd_r    <= 4'd0;
      valido_r <= 1'b0;
      nova_r   <= 1'b0;
    end else if (bus.enablen) begin
      bcd_r    <= 4'd0;
      valido_r <= 1'b0;
      nova_r   <= 1'b0;
    end else if (accept_s) begin
      bcd_r    <= any_s ? code_s : 4'd0;
      valido_r <= any_s;
      nova_r   <= nova_s;
    end else begin
      bcd_r    <= bcd_r;
      valido_r <= valido_r;
      nova_r   <= 1'b0;
    end
  end

  assign bus.BCD        = bcd_r;
  assign bus.valido     = valido_r;
  assign bus.nova_tecla = nova_r;

endmodule

// File: tb/tb_codificador_prioritario.sv
// Directed, table-driven bench for codificador_prioritario.
module tb_codificador_prioritario;

  typedef struct {
    logic [9:0] entrada;
    logic       enablen;
    logic [3:0] bcd;
    logic       valido;
    logic       nova;
    string      name;
  } vec_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  vec_t tbl[$];

  codificador_prioritario_if bus_if ();

  codificador_prioritario dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic [9:0] e, input logic en, input logic [3:0] b,
                     input logic v, input logic n, input string nm);
    vec_t t;
    t.entrada = e; t.enablen = en; t.bcd = b; t.valido = v; t.nova = n; t.name = nm;
    tbl.push_back(t);
  endtask

  task automatic step(input logic [9:0] e, input logic en, input logic r);
    @(negedge clk);
    bus_if.entrada = e;
    bus_if.enablen = en;
    reset          = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [3:0] b, input logic v, input logic n);
    n_cmp++;
    if ((bus_if.BCD !== b) || (bus_if.valido !== v) || (bus_if.nova_tecla !== n)) begin
      n_err++;
      $display("FAIL %s: got BCD=%0d valido=%b nova_tecla=%b, want BCD=%0d valido=%b nova_tecla=%b",
               nm, bus_if.BCD, bus_if.valido, bus_if.nova_tecla, b, v, n);
    end
  endtask

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    reset          = 1'b1;
    bus_if.entrada = 10'd0;
    bus_if.enablen = 1'b1;

    // Reset held two clocks with key 9 pressed and encoder enabled.
    step(10'b1000000000, 1'b0, 1'b1);
    check("reset_clk1", 4'd0, 1'b0, 1'b0);
    step(10'b1000000000, 1'b0, 1'b1);
    check("reset_clk2", 4'd0, 1'b0, 1'b0);

`ifdef CODIFICADOR_DEBOUNCE_EN
    for (int k = 0; k < 6; k++) begin
      step(10'd0, 1'b0, 1'b0);
      check("deb_idle", 4'd0, 1'b0, 1'b0);
    end
    for (int k = 0; k < 2; k++) begin
      step(10'b0010000000, 1'b0, 1'b0);
      check("deb_glitch", 4'd0, 1'b0, 1'b0);
    end
    for (int k = 0; k < 6; k++) begin
      step(10'd0, 1'b0, 1'b0);
      check("deb_after_glitch", 4'd0, 1'b0, 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      step(10'b0010000000, 1'b0, 1'b0);
      check("deb_hold_wait", 4'd0, 1'b0, 1'b0);
    end
    step(10'b0010000000, 1'b0, 1'b0);
    check("deb_accept", 4'd7, 1'b1, 1'b1);
    step(10'b0010000000, 1'b0, 1'b0);
    check("deb_hold", 4'd7, 1'b1, 1'b0);
    step(10'b0010000000, 1'b1, 1'b0);
    check("deb_disable", 4'd0, 1'b0, 1'b0);
`else
    step(10'b1000000000, 1'b0, 1'b0);
    check("reset_release", 4'd9, 1'b1, 1'b1);

    // One-hot sweep, enabled: each digit held three clocks, one pulse per change.
    for (int i = 9; i >= 0; i--) begin
      for (int j = 0; j < 3; j++) begin
        add(10'(1) << i, 1'b0, 4'(i), 1'b1, (j == 0) && (i != 9), "sweep_en");
      end
    end
    // Same sweep disabled.
    for (int i = 9; i >= 0; i--) begin
      add(10'(1) << i, 1'b1, 4'd0, 1'b0, 1'b0, "sweep_dis");
    end
    // Priority: lower bits ignored, no pulse while digit unchanged.
    add(10'b1000000001, 1'b0, 4'd9, 1'b1, 1'b1, "prio_9_0");
    add(10'b1000001001, 1'b0, 4'd9, 1'b1, 1'b0, "prio_9_3_0");
    add(10'b1000001001, 1'b1, 4'd0, 1'b0, 1'b0, "prio_disabled");
    // Release and re-press of the same digit.
    add(10'b0000100000, 1'b0, 4'd5, 1'b1, 1'b1, "press_5");
    add(10'b0000000000, 1'b0, 4'd0, 1'b0, 1'b0, "release");
    add(10'b0000100000, 1'b0, 4'd5, 1'b1, 1'b1, "repress_5");
    add(10'b0000100000, 1'b0, 4'd5, 1'b1, 1'b0, "hold_5");
    // Re-enable after disable with the same key pulses again.
    add(10'b0000100000, 1'b1, 4'd0, 1'b0, 1'b0, "disable_5");
    add(10'b0000100000, 1'b0, 4'd5, 1'b1, 1'b1, "reenable_5");
    // Digit change without release, then a higher key on top.
    add(10'b0000000100, 1'b0, 4'd2, 1'b1, 1'b1, "change_2");
    add(10'b0100000100, 1'b0, 4'd8, 1'b1, 1'b1, "higher_8");
    add(10'b0000000000, 1'b1, 4'd0, 1'b0, 1'b0, "dis_and_release");

    foreach (tbl[k]) begin
      step(tbl[k].entrada, tbl[k].enablen, 1'b0);
      check(tbl[k].name, tbl[k].bcd, tbl[k].valido, tbl[k].nova);
    end

    // Reset mid-operation clears state, then key reappears as new.
    step(10'b0001000000, 1'b0, 1'b0);
    check("pre_midreset", 4'd6, 1'b1, 1'b1);
    step(10'b0001000000, 1'b0, 1'b1);
    check("midreset", 4'd0, 1'b0, 1'b0);
    step(10'b0001000000, 1'b0, 1'b0);
    check("post_midreset", 4'd6, 1'b1, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
